// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1/8E1/8O1/8x2 UART transmitter with a valid/ready byte input.
// One byte in flight: the byte is latched on accept and serialised LSB first
// as start bit, eight data bits, optional parity bit and one or two stop bits.
// Every output is a flop whose next value is derived from the next state, so
// tx only moves on bit boundaries or on reset.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int            CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_ZERO  = CW'(0);
  localparam logic [CW-1:0] BAUD_ONE   = CW'(1);
  localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    DATA_LAST  = 3'd7;
  localparam logic [2:0]    STOP_LAST  = 3'(STOP_BITS - 1);
  localparam logic          PAR_INV    = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
  localparam bit            HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Even parity is the XOR of all data bits; odd parity is its inverse.
  function automatic logic parity_of(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          baud_last_s;

  assign baud_last_s = (baud_q == BAUD_LAST);

  // Frame sequencing: baud counter paces each bit, bit counter walks data and stop bits.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    case (state_q)
      S_IDLE: begin
        baud_d = BAUD_ZERO;
        bit_d  = 3'd0;
        if (tx_valid && ready_q) begin
          state_d  = S_START;
          shift_d  = tx_data;
          parity_d = parity_of(tx_data, PAR_INV);
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_START: begin
        if (baud_last_s) begin
          baud_d  = BAUD_ZERO;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
      S_DATA: begin
        if (baud_last_s) begin
          baud_d  = BAUD_ZERO;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = 3'd0;
            state_d = HAS_PARITY ? S_PARITY : S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
      S_PARITY: begin
        if (baud_last_s) begin
          baud_d  = BAUD_ZERO;
          bit_d   = 3'd0;
          state_d = S_STOP;
        end else begin
          baud_d  = baud_q + BAUD_ONE;
        end
      end
      S_STOP: begin
        if (baud_last_s) begin
          baud_d = BAUD_ZERO;
          if (bit_q == STOP_LAST) begin
            bit_d   = 3'd0;
            state_d = S_IDLE;
          end else begin
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = BAUD_ZERO;
        bit_d   = 3'd0;
      end
    endcase
  end

  // Output values for the coming cycle, taken from the state being entered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = parity_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
  end

  // State and output registers with synchronous reset to an idle-high line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= BAUD_ZERO;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign tx         = tx_q;
  assign tx_ready   = ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- Serial UART transmitter, 8 data bits, LSB first, optional parity, 1 or 2 stop bits.
- Accepts bytes over a valid/ready handshake and drives one idle-high serial line.
- Forms the transmit end of the board-level debug/config link. Its output drives a design's dedicated input pin, and its peer receiver samples that pin.
- Single clock domain; no internal FIFO (one byte in flight).

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535; counter width is clog2(CLKS_PER_BIT).
- PARITY_EN, 0, 1 = insert a parity bit after bit 7.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous active-high reset.
- tx_data  input  8  byte to send; sampled only on an accept cycle.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  block can accept a byte this cycle.
- tx  output  1  serial line, idle high.
- busy  output  1  frame in progress (any state other than IDLE).
- frame_done  output  1  one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Reset: any cycle with rst=1 forces the following on the next edge:
  - state IDLE, tx=1, tx_ready=1, busy=0, frame_done=0;
  - bit counter and baud counter = 0;
  - shift register = 0.
  - rst overrides tx_valid in the same cycle.
- Reset mid-frame: the frame is abandoned and tx returns high on the next edge. No frame_done is emitted.
- tx_ready is 1 only in IDLE (registered, equal to state==IDLE).
- Accept: tx_valid=1 and tx_ready=1 at a rising edge. On that edge:
  - tx_data is latched into the shift register;
  - parity is computed from tx_data (even: XOR of bits; odd: inverted XOR);
  - state moves to START.
- tx_data and tx_valid changes while busy are ignored. No byte is lost or duplicated.
- tx is registered. It goes low in the first cycle after the accept edge.
- State machine: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
  - Each serial bit holds tx for exactly CLKS_PER_BIT cycles.
  - The baud counter runs 0..CLKS_PER_BIT-1. It wraps to 0 on each bit boundary and is never free-running across IDLE.
  - START: tx=0.
  - DATA: tx = shift register bit 0. Shift right at each bit boundary; bit counter runs 0..7. Leave DATA after bit 7 completes.
  - PARITY: tx = latched parity bit.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 on the final cycle of STOP. The next edge returns to IDLE with tx_ready=1.
- Frame length, first low cycle to last stop cycle inclusive: (1+8+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back: if tx_valid is held high, the next accept occurs on the first IDLE cycle. The minimum idle-high gap between frames is therefore exactly 1 clock beyond the stop bits.
- tx never glitches: it changes only at bit boundaries or on reset.

Test Plan:
- Reset and idle: CLKS_PER_BIT=4; assert rst for 3 cycles with tx_valid=1 -> tx=1, tx_ready=1, busy=0 throughout. No accept occurs during reset.
- Basic frame: CLKS_PER_BIT=4, defaults otherwise; send 0xA5 -> tx shows bits 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), 4 cycles each.
  - 40 cycles total from the first low cycle.
  - frame_done pulses once on cycle 40; tx_ready returns 1 on cycle 41.
- Parity: PARITY_EN=1; send 0x07.
  - PARITY_ODD=0 -> parity bit 1.
  - PARITY_ODD=1 -> parity bit 0.
  - Frame length is 44 cycles at CLKS_PER_BIT=4.
- Back-to-back and ignored input: hold tx_valid=1; present 0x01 then 0xFF; change tx_data to 0x3C mid-frame -> the first frame still carries 0x01 and the second carries 0xFF. The gap between frames is exactly 1 extra high cycle.
- Reset mid-frame: assert rst during data bit 3 of 0x00 -> tx=1 on the next edge, frame_done never pulses. A subsequent send of 0x81 produces a clean, correct frame.
- Two stop bits: STOP_BITS=2, CLKS_PER_BIT=2; send 0xFF -> stop phase is 4 cycles high and total frame is 22 cycles. A checker receiver decodes 0xFF.
